// File: rtl/i2s_pkg.sv
// Shared framing constants, FSM state type and RAM write payload for the MSB-justified I2S receiver.
package i2s_pkg;

    localparam int unsigned SLOT_BITS       = 32;
    localparam int unsigned SLOTS_PER_FRAME = 2;
    localparam int unsigned FRAME_BITS      = SLOT_BITS * SLOTS_PER_FRAME;
    localparam int unsigned RAM_ADDR_BITS   = 11;
    localparam int unsigned BIT_IDX_BITS    = $clog2(SLOT_BITS);
    localparam int unsigned SLOT_CNT_BITS   = BIT_IDX_BITS + 1;

    typedef enum logic {
        HUNT,
        RUN
    } i2s_rx_state_e;

    typedef struct packed {
        logic [RAM_ADDR_BITS-1:0] addr;
        logic                     data;
    } ram_wr_t;

endpackage

// File: rtl/sync_edge_detector.sv
// Two-flop synchronizer for an asynchronous pin plus single-cycle rise/fall pulses.
module sync_edge_detector (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic sync,
    output logic rise_c,
    output logic fall_c
);

    logic meta;
    logic sync_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta   <= 1'b0;
            sync   <= 1'b0;
            sync_d <= 1'b0;
        end else begin
            meta   <= din;
            sync   <= meta;
            sync_d <= sync;
        end
    end

    assign rise_c = sync & ~sync_d;
    assign fall_c = ~sync & sync_d;

endmodule

// File: rtl/i2s_msb_receiver.sv
// MSB-justified I2S receiver: frames the serial stream and writes each bit into a circular
// bit-wide frame buffer, reporting the newest complete frame and lock status.
module i2s_msb_receiver
    import i2s_pkg::*;
#(
    parameter int unsigned CIRC_BUF_BITS = 3
) (
    input  logic                     clk_x4_i,
    input  logic                     rst_n_i,
    input  logic                     i2s_bclk_i,
    input  logic                     i2s_lrclk_i,
    input  logic                     i2s_data_i,
    output logic [RAM_ADDR_BITS-1:0] ram_write_addr_o,
    output logic                     ram_write_data_o,
    output logic                     ram_wr_en_o,
    output logic [CIRC_BUF_BITS-1:0] last_good_frame_idx_o,
    output logic                     frame_done_o,
    output logic                     sync_error_o,
    output logic                     locked_o,
    output logic                     resync_req_o
);

    localparam int unsigned USED_ADDR_BITS = CIRC_BUF_BITS + $clog2(FRAME_BITS);
    localparam logic [SLOT_CNT_BITS-1:0] FULL_SLOT = SLOT_CNT_BITS'(SLOT_BITS);
    localparam logic [SLOT_CNT_BITS-1:0] ONE_BIT   = SLOT_CNT_BITS'(1);

    logic bclk_s, bclk_rise_c, bclk_fall_c;
    logic lr_s, lr_pin_rise_c, lr_pin_fall_c;
    logic data_s, data_rise_c, data_fall_c;
    logic unused_edges;

    sync_edge_detector u_sync_bclk (
        .clk    (clk_x4_i),
        .rst_n  (rst_n_i),
        .din    (i2s_bclk_i),
        .sync   (bclk_s),
        .rise_c (bclk_rise_c),
        .fall_c (bclk_fall_c)
    );

    sync_edge_detector u_sync_lrclk (
        .clk    (clk_x4_i),
        .rst_n  (rst_n_i),
        .din    (i2s_lrclk_i),
        .sync   (lr_s),
        .rise_c (lr_pin_rise_c),
        .fall_c (lr_pin_fall_c)
    );

    sync_edge_detector u_sync_data (
        .clk    (clk_x4_i),
        .rst_n  (rst_n_i),
        .din    (i2s_data_i),
        .sync   (data_s),
        .rise_c (data_rise_c),
        .fall_c (data_fall_c)
    );

    // LRCLK transitions only matter as seen at BCLK sampling points, not at pin rate.
    assign unused_edges = ^{bclk_s, bclk_fall_c, lr_pin_rise_c, lr_pin_fall_c, data_rise_c, data_fall_c};

    function automatic logic [RAM_ADDR_BITS-1:0] make_addr(
        input logic [CIRC_BUF_BITS-1:0] idx,
        input logic                     lr,
        input logic [BIT_IDX_BITS-1:0]  bit_idx
    );
        logic [USED_ADDR_BITS-1:0] a;
        a = {idx, lr, bit_idx};
        return RAM_ADDR_BITS'(a);
    endfunction

    i2s_rx_state_e              state_q, state_d;
    logic [CIRC_BUF_BITS-1:0]   frame_idx_q, frame_idx_d;
    logic [CIRC_BUF_BITS-1:0]   last_good_q, last_good_d;
    logic [SLOT_CNT_BITS-1:0]   bit_cnt_q, bit_cnt_d;
    logic                       lr_prev_q, lr_prev_d;
    logic                       locked_q, locked_d;
    logic                       resync_q;
    ram_wr_t                    wr_q, wr_d;
    logic                       wr_en_q, wr_en_d;
    logic                       done_q, done_d;
    logic                       err_q, err_d;

    logic                       lr_change_c, lr_fall_c, slot_full_c;
    logic [BIT_IDX_BITS-1:0]    wr_bit_c;

    assign lr_change_c = lr_s ^ lr_prev_q;
    assign lr_fall_c   = lr_prev_q & ~lr_s;
    assign slot_full_c = (bit_cnt_q == FULL_SLOT);

    always_ff @(posedge clk_x4_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= HUNT;
            frame_idx_q <= '0;
            last_good_q <= '0;
            bit_cnt_q   <= '0;
            lr_prev_q   <= 1'b0;
            locked_q    <= 1'b0;
            resync_q    <= 1'b1;
            wr_q        <= '0;
            wr_en_q     <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            frame_idx_q <= frame_idx_d;
            last_good_q <= last_good_d;
            bit_cnt_q   <= bit_cnt_d;
            lr_prev_q   <= lr_prev_d;
            locked_q    <= locked_d;
            resync_q    <= ~locked_d;
            wr_q        <= wr_d;
            wr_en_q     <= wr_en_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    // Framing: every slot must carry exactly 32 bits between LRCLK transitions.
    always_comb begin
        state_d     = state_q;
        frame_idx_d = frame_idx_q;
        last_good_d = last_good_q;
        bit_cnt_d   = bit_cnt_q;
        lr_prev_d   = lr_prev_q;
        locked_d    = locked_q;
        wr_d        = wr_q;
        wr_en_d     = 1'b0;
        done_d      = 1'b0;
        err_d       = 1'b0;
        wr_bit_c    = '0;

        if (bclk_rise_c) begin
            lr_prev_d = lr_s;
            case (state_q)
                HUNT: begin
                    if (lr_fall_c) begin
                        state_d   = RUN;
                        wr_en_d   = 1'b1;
                        bit_cnt_d = ONE_BIT;
                    end
                end
                RUN: begin
                    if (lr_change_c && slot_full_c) begin
                        wr_en_d   = 1'b1;
                        bit_cnt_d = ONE_BIT;
                        if (lr_fall_c) begin
                            last_good_d = frame_idx_q;
                            frame_idx_d = frame_idx_q + CIRC_BUF_BITS'(1);
                            done_d      = 1'b1;
                            locked_d    = 1'b1;
                        end
                    end else if (lr_change_c || slot_full_c) begin
                        err_d    = 1'b1;
                        locked_d = 1'b0;
                        state_d  = HUNT;
                        // A falling LRCLK that exposes the error is itself a valid frame start.
                        if (lr_fall_c) begin
                            state_d   = RUN;
                            wr_en_d   = 1'b1;
                            bit_cnt_d = ONE_BIT;
                        end
                    end else begin
                        wr_en_d   = 1'b1;
                        wr_bit_c  = bit_cnt_q[BIT_IDX_BITS-1:0];
                        bit_cnt_d = bit_cnt_q + ONE_BIT;
                    end
                end
                default: state_d = HUNT;
            endcase

            if (wr_en_d) begin
                wr_d.addr = make_addr(frame_idx_d, lr_s, wr_bit_c);
                wr_d.data = data_s;
            end
        end
    end

    assign ram_write_addr_o      = wr_q.addr;
    assign ram_write_data_o      = wr_q.data;
    assign ram_wr_en_o           = wr_en_q;
    assign last_good_frame_idx_o = last_good_q;
    assign frame_done_o          = done_q;
    assign sync_error_o          = err_q;
    assign locked_o              = locked_q;
    assign resync_req_o          = resync_q;

endmodule

// File: tb/tb_i2s_msb_receiver.sv
// Directed bench for i2s_msb_receiver: slot-level framing model feeding expected write/commit/error queues.
module tb_i2s_msb_receiver;

    localparam int unsigned CBB = 3;
    localparam int          NFR = 1 << CBB;

    logic           clk   = 1'b0;
    logic           rst_n = 1'b1;
    logic           bclk  = 1'b0;
    logic           lrclk = 1'b0;
    logic           data  = 1'b0;
    logic [10:0]    ram_write_addr;
    logic           ram_write_data;
    logic           ram_wr_en;
    logic [CBB-1:0] last_good;
    logic           frame_done;
    logic           sync_error;
    logic           locked;
    logic           resync_req;

    always #5 clk = ~clk;

    i2s_msb_receiver #(.CIRC_BUF_BITS(CBB)) dut (
        .clk_x4_i              (clk),
        .rst_n_i               (rst_n),
        .i2s_bclk_i            (bclk),
        .i2s_lrclk_i           (lrclk),
        .i2s_data_i            (data),
        .ram_write_addr_o      (ram_write_addr),
        .ram_write_data_o      (ram_write_data),
        .ram_wr_en_o           (ram_wr_en),
        .last_good_frame_idx_o (last_good),
        .frame_done_o          (frame_done),
        .sync_error_o          (sync_error),
        .locked_o              (locked),
        .resync_req_o          (resync_req)
    );

    int checks = 0;
    int errors = 0;
    int n_done = 0;
    int n_err  = 0;
    int err_lg_seen = -1;

    int          seg_lr[$];
    int          seg_n[$];
    logic [31:0] seg_w[$];

    int exp_wr_addr[$];
    int exp_wr_data[$];
    int exp_commit[$];
    int exp_err[$];

    logic        dut_ram [0:2047];
    logic [31:0] src_l [0:4];
    logic [31:0] src_r [0:4];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: every DUT strobe is matched against the model's ordered expectations.
    always @(negedge clk) begin
        chk("resync_vs_locked", int'(resync_req), int'(!locked));
        if (ram_wr_en) begin
            if (exp_wr_addr.size() == 0) begin
                chk("wr_unexpected", int'(ram_write_addr), -1);
            end else begin
                chk("wr_addr", int'(ram_write_addr), exp_wr_addr.pop_front());
                chk("wr_data", int'(ram_write_data), exp_wr_data.pop_front());
            end
            dut_ram[ram_write_addr] = ram_write_data;
        end
        if (frame_done) begin
            n_done++;
            if (exp_commit.size() == 0) chk("done_unexpected", int'(last_good), -1);
            else                        chk("done_idx", int'(last_good), exp_commit.pop_front());
            chk("done_locked", int'(locked), 1);
        end
        if (sync_error) begin
            n_err++;
            err_lg_seen = int'(last_good);
            if (exp_err.size() == 0) chk("err_unexpected", int'(last_good), -1);
            else                     chk("err_last_good", int'(last_good), exp_err.pop_front());
            chk("err_locked", int'(locked), 0);
        end
    end

    task automatic add_seg(input int lr, input int n, input logic [31:0] w);
        seg_lr.push_back(lr);
        seg_n.push_back(n);
        seg_w.push_back(w);
    endtask

    task automatic add_frame(input logic [31:0] l, input logic [31:0] r);
        add_seg(0, 32, l);
        add_seg(1, 32, r);
    endtask

    // Slot-level model: a run always starts from the reset state.
    task automatic model_run();
        int idx = 0;
        int lg = 0;
        int prev_lr = 0;
        int prev_n = 0;
        bit hunting = 1'b1;
        for (int i = 0; i < seg_n.size(); i++) begin
            int          lr   = seg_lr[i];
            int          n    = seg_n[i];
            logic [31:0] w    = seg_w[i];
            bit          fall = (prev_lr == 1) && (lr == 0);
            bit          wseg = 1'b0;
            if (!hunting && lr != prev_lr) begin
                if (prev_n == 32) begin
                    if (fall) begin
                        exp_commit.push_back(idx);
                        lg  = idx;
                        idx = (idx + 1) % NFR;
                    end
                    wseg = 1'b1;
                end else begin
                    exp_err.push_back(lg);
                    hunting = 1'b1;
                end
            end
            if (hunting && fall) begin
                hunting = 1'b0;
                wseg    = 1'b1;
            end
            if (wseg) begin
                for (int k = 0; k < ((n < 32) ? n : 32); k++) begin
                    exp_wr_addr.push_back(idx * 64 + lr * 32 + k);
                    exp_wr_data.push_back(int'(w[31-k]));
                end
                if (n > 32) begin
                    exp_err.push_back(lg);
                    hunting = 1'b1;
                end
            end
            prev_lr = lr;
            prev_n  = n;
        end
    endtask

    // BCLK = clk/4; LRCLK/DATA change while BCLK is low, MSB first.
    task automatic run_stream(input string name);
        logic [31:0] w;
        model_run();
        for (int i = 0; i < seg_n.size(); i++) begin
            w = seg_w[i];
            for (int k = 0; k < seg_n[i]; k++) begin
                lrclk = seg_lr[i][0];
                data  = w[31 - (k % 32)];
                repeat (2) @(negedge clk);
                bclk = 1'b1;
                repeat (2) @(negedge clk);
                bclk = 1'b0;
            end
        end
        repeat (12) @(negedge clk);
        chk({name, "_drain_wr"}, exp_wr_addr.size(), 0);
        chk({name, "_drain_done"}, exp_commit.size(), 0);
        chk({name, "_drain_err"}, exp_err.size(), 0);
        exp_wr_addr.delete();
        exp_wr_data.delete();
        exp_commit.delete();
        exp_err.delete();
        seg_lr.delete();
        seg_n.delete();
        seg_w.delete();
    endtask

    task automatic check_reset_vals(input string name);
        chk({name, "_wr_en"}, int'(ram_wr_en), 0);
        chk({name, "_wr_addr"}, int'(ram_write_addr), 0);
        chk({name, "_wr_data"}, int'(ram_write_data), 0);
        chk({name, "_last_good"}, int'(last_good), 0);
        chk({name, "_done"}, int'(frame_done), 0);
        chk({name, "_err"}, int'(sync_error), 0);
        chk({name, "_locked"}, int'(locked), 0);
        chk({name, "_resync"}, int'(resync_req), 1);
    endtask

    task automatic pulse_reset(input string name, input int cycles);
        bclk  = 1'b0;
        rst_n = 1'b0;
        repeat (cycles) @(negedge clk);
        check_reset_vals(name);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        n_done      = 0;
        n_err       = 0;
        err_lg_seen = -1;
    endtask

    initial begin
        logic [31:0] w;
        for (int a = 0; a < 2048; a++) dut_ram[a] = 1'b0;
        #1;

        // Reset held 20 cycles
        pulse_reset("t1", 20);

        // Clean stream, 10 frames
        add_seg(1, 4, 32'hFFFF_FFFF);
        for (int f = 0; f < 10; f++) add_frame(32'hA5A5_A5A5, 32'h1234_5678);
        run_stream("t2");
        chk("t2_done_count", n_done, 9);
        chk("t2_err_count", n_err, 0);
        chk("t2_last_good", int'(last_good), 0);
        chk("t2_locked", int'(locked), 1);
        chk("t2_ram_l_b0", int'(dut_ram[0]), 1);
        chk("t2_ram_l_b1", int'(dut_ram[1]), 0);
        chk("t2_ram_r_b0", int'(dut_ram[32]), 0);
        chk("t2_ram_r_b3", int'(dut_ram[35]), 1);
        chk("t2_ram_f7_r_b28", int'(dut_ram[7*64 + 32 + 28]), 1);

        // Start mid-right-slot
        pulse_reset("t3_rst", 5);
        add_seg(1, 14, 32'hFFFF_0000);
        for (int f = 0; f < 3; f++) add_frame(32'hDEAD_BEEF, 32'h0F0F_0F0F);
        run_stream("t3");
        chk("t3_done_count", n_done, 2);
        chk("t3_last_good", int'(last_good), 1);

        // Left slot truncated to 31 bits in frame 3
        pulse_reset("t4_rst", 5);
        add_seg(1, 4, 32'h0);
        for (int f = 0; f < 3; f++) add_frame(32'hC3C3_0001, 32'h8000_7FFF);
        add_seg(0, 31, 32'hFFFF_FFFF);
        add_seg(1, 32, 32'h5555_AAAA);
        for (int f = 0; f < 2; f++) add_frame(32'h0123_4567, 32'h89AB_CDEF);
        run_stream("t4");
        chk("t4_err_count", n_err, 1);
        chk("t4_err_last_good", err_lg_seen, 2);
        chk("t4_done_count", n_done, 4);
        chk("t4_last_good", int'(last_good), 3);
        chk("t4_locked", int'(locked), 1);

        // 40-bit right slot
        pulse_reset("t5_rst", 5);
        add_seg(1, 4, 32'h0);
        add_frame(32'h1111_2222, 32'h3333_4444);
        add_seg(0, 32, 32'h5555_6666);
        add_seg(1, 40, 32'hF0F0_F0F0);
        for (int f = 0; f < 2; f++) add_frame(32'h7777_8888, 32'h9999_AAAA);
        run_stream("t5");
        chk("t5_err_count", n_err, 1);
        chk("t5_err_last_good", err_lg_seen, 0);
        chk("t5_done_count", n_done, 2);
        chk("t5_last_good", int'(last_good), 1);

        // Reset pulse at bit 17 of frame 5
        pulse_reset("t6_rst", 5);
        add_seg(1, 4, 32'h0);
        for (int f = 0; f < 5; f++) add_frame(32'hA0A0_0505, 32'h5A5A_C3C3);
        add_seg(0, 17, 32'hBEEF_CAFE);
        run_stream("t6a");
        chk("t6a_done_count", n_done, 5);
        chk("t6a_last_good", int'(last_good), 4);
        pulse_reset("t6_mid", 3);
        add_seg(0, 15, 32'hBEEF_CAFE);
        add_seg(1, 32, 32'h1357_9BDF);
        for (int f = 0; f < 2; f++) add_frame(32'h2468_ACE0, 32'hFEDC_BA98);
        run_stream("t6b");
        chk("t6b_done_count", n_done, 1);
        chk("t6b_last_good", int'(last_good), 0);

        // Loopback of a transmitted frame buffer
        pulse_reset("t7_rst", 5);
        for (int a = 0; a < 2048; a++) dut_ram[a] = 1'b0;
        add_seg(1, 4, 32'h0);
        for (int f = 0; f < 5; f++) begin
            src_l[f] = $urandom;
            src_r[f] = $urandom;
            add_frame(src_l[f], src_r[f]);
        end
        run_stream("t7");
        chk("t7_done_count", n_done, 4);
        for (int f = 0; f < 4; f++) begin
            for (int b = 0; b < 32; b++) w[31-b] = dut_ram[f*64 + b];
            chk("t7_left_word", int'(w), int'(src_l[f]));
            for (int b = 0; b < 32; b++) w[31-b] = dut_ram[f*64 + 32 + b];
            chk("t7_right_word", int'(w), int'(src_r[f]));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
